alu_sequencer: RTL and testbench

- Control-side counterpart to the combinational `alu`. It accepts one 16-bit Hack-format instruction at a time over a valid/ready handshake.
- It decodes the instruction into the `alu` control bits (zx, nx, zy, ny, f, no) and drives the x/y operands.
- It samples the `alu` result, then writes back to the A/D registers and/or memory and evaluates the jump condition.
- It sits between instruction fetch and the existing `alu` instance. The `alu` is instantiated outside this block; this block only drives and reads its ports.

---
 rtl/lvm_pkg.sv | 40 ++++
 rtl/alu_sequencer_if.sv | 13 +
 rtl/alu_sequencer_jump_eval.sv | 20 ++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvm_pkg.sv
// Shared definitions for the Hack-style ALU sequencer: word width,
// instruction field positions, FSM state encoding and ALU control bundle.
package lvm_pkg;

    localparam int WORD_W = 16;

    // Instruction field bit positions
    localparam int CBIT    = 15;   // 1 = C-instruction, 0 = A-instruction
    localparam int ABIT    = 12;   // y operand select: 1 = M, 0 = A
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Field order matches the comp field, MSB first
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    function automatic logic is_c_instr(word_t i);
        return i[CBIT];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction fetch handshake: the producer drives instr/instr_valid and
// holds them until instr_ready is seen high at a clock edge.
interface alu_sequencer_if;
    import lvm_pkg::*;

    logic  instr_valid;
    logic  instr_ready;
    word_t instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_sequencer_jump_eval.sv
// Jump condition evaluation from an ALU result and the 3-bit jump field.
// Kept standalone so a future PC unit can reuse it.
module jump_eval
    import lvm_pkg::*;
(
    input  word_t      result,
    input  logic [2:0] jbits,
    output logic       zr,
    output logic       ng,
    output logic       jump_taken
);

    // Flags and jump decision: jbits = {lt, eq, gt}
    always_comb begin
        zr         = (result == '0);
        ng         = result[WORD_W-1];
        jump_taken = (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~ng & ~zr);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control side of the external combinational ALU: accepts one instruction,
// drives ALU controls/operands for ALU_LAT cycles, then retires it in a
// single write-back cycle (register/memory writes, jump evaluation).
module alu_sequencer
    import lvm_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1   // legal range 1..15
)
(
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave ibus,
    input  word_t          m_in,
    output logic           zx,
    output logic           nx,
    output logic           zy,
    output logic           ny,
    output logic           f,
    output logic           no,
    output word_t          alu_x,
    output word_t          alu_y,
    input  word_t          alu_out,
    output word_t          m_addr,
    output word_t          m_out,
    output logic           m_we,
    output word_t          a_reg,
    output word_t          d_reg,
    output logic           jump_taken,
    output word_t          jump_target,
    output logic           done
);

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t     state, state_nxt;
    word_t      instr_q;
    word_t      result_q;
    logic [3:0] lat_cnt;
    logic       ready;
    logic       accept;
    alu_ctrl_t  ctrl;
    logic       jt;
    logic       zr_unused;   // flags are consumed by the future PC unit only
    logic       ng_unused;

    assign ibus.instr_ready = ready;
    assign accept           = ibus.instr_valid & ready;
    assign m_addr           = a_reg;
    assign {zx, nx, zy, ny, f, no} = ctrl;

    jump_eval u_jump_eval (
        .result     (result_q),
        .jbits      (instr_q[JMP_HI:JMP_LO]),
        .zr         (zr_unused),
        .ng         (ng_unused),
        .jump_taken (jt)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Instruction latch, latency counter, result capture and A/D write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            lat_cnt  <= '0;
            a_reg    <= '0;
            d_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= ibus.instr;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) result_q <= alu_out;
                    else               lat_cnt  <= lat_cnt - 4'd1;
                end
                WB: begin
                    if (!is_c_instr(instr_q)) begin
                        a_reg <= {1'b0, instr_q[WORD_W-2:0]};
                    end else begin
                        if (instr_q[DEST_A]) a_reg <= result_q;
                        if (instr_q[DEST_D]) d_reg <= result_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt   = state;
        ready       = 1'b0;
        ctrl        = '0;
        alu_x       = '0;
        alu_y       = '0;
        m_out       = '0;
        m_we        = 1'b0;
        jump_taken  = 1'b0;
        jump_target = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (ibus.instr_valid) state_nxt = is_c_instr(ibus.instr) ? EXEC : WB;
            end
            EXEC: begin
                ctrl  = alu_ctrl_t'(instr_q[COMP_HI:COMP_LO]);
                alu_x = d_reg;
                alu_y = instr_q[ABIT] ? m_in : a_reg;
                if (lat_cnt == '0) state_nxt = WB;
            end
            WB: begin
                done = 1'b1;
                if (is_c_instr(instr_q)) begin
                    m_we        = instr_q[DEST_M];
                    m_out       = result_q;
                    jump_taken  = jt;
                    jump_target = a_reg;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: two sequencers (ALU_LAT=1 and ALU_LAT=3), a
// bit-level ALU stub and memory fixture, and a mnemonic-level reference
// model of the Hack instruction set.
module tb_alu_sequencer;
    import lvm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;        // 0 selects dut_l1, 1 selects dut_l3
    logic        valid_drv;
    logic [15:0] instr_drv;

    alu_sequencer_if if_l1();
    alu_sequencer_if if_l3();

    assign if_l1.instr_valid = valid_drv & ~sel;
    assign if_l1.instr       = instr_drv;
    assign if_l3.instr_valid = valid_drv & sel;
    assign if_l3.instr       = instr_drv;

    logic [1:0] zx_v, nx_v, zy_v, ny_v, f_v, no_v, m_we_v, jump_v, done_v;
    word_t alu_x_v [2];
    word_t alu_y_v [2];
    word_t alu_out_v [2];
    word_t m_in_v [2];
    word_t m_addr_v [2];
    word_t m_out_v [2];
    word_t a_v [2];
    word_t d_v [2];
    word_t jt_v [2];

    alu_sequencer #(.ALU_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .ibus(if_l1), .m_in(m_in_v[0]),
        .zx(zx_v[0]), .nx(nx_v[0]), .zy(zy_v[0]), .ny(ny_v[0]), .f(f_v[0]), .no(no_v[0]),
        .alu_x(alu_x_v[0]), .alu_y(alu_y_v[0]), .alu_out(alu_out_v[0]),
        .m_addr(m_addr_v[0]), .m_out(m_out_v[0]), .m_we(m_we_v[0]),
        .a_reg(a_v[0]), .d_reg(d_v[0]), .jump_taken(jump_v[0]),
        .jump_target(jt_v[0]), .done(done_v[0])
    );

    alu_sequencer #(.ALU_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .ibus(if_l3), .m_in(m_in_v[1]),
        .zx(zx_v[1]), .nx(nx_v[1]), .zy(zy_v[1]), .ny(ny_v[1]), .f(f_v[1]), .no(no_v[1]),
        .alu_x(alu_x_v[1]), .alu_y(alu_y_v[1]), .alu_out(alu_out_v[1]),
        .m_addr(m_addr_v[1]), .m_out(m_out_v[1]), .m_we(m_we_v[1]),
        .a_reg(a_v[1]), .d_reg(d_v[1]), .jump_taken(jump_v[1]),
        .jump_target(jt_v[1]), .done(done_v[1])
    );

    // Bit-level stand-in for the external combinational ALU
    function automatic word_t alu_fn(logic zx, logic nx, logic zy, logic ny,
                                     logic f, logic no, word_t x, word_t y);
        word_t xa, ya, o;
        xa = zx ? 16'h0000 : x;
        xa = nx ? ~xa : xa;
        ya = zy ? 16'h0000 : y;
        ya = ny ? ~ya : ya;
        o  = f ? xa + ya : xa & ya;
        return no ? ~o : o;
    endfunction

    assign alu_out_v[0] = alu_fn(zx_v[0], nx_v[0], zy_v[0], ny_v[0], f_v[0], no_v[0], alu_x_v[0], alu_y_v[0]);
    assign alu_out_v[1] = alu_fn(zx_v[1], nx_v[1], zy_v[1], ny_v[1], f_v[1], no_v[1], alu_x_v[1], alu_y_v[1]);

    // Memory fixture, aliased on the low 8 address bits
    word_t mem [256];
    assign m_in_v[0] = mem[m_addr_v[0][7:0]];
    assign m_in_v[1] = mem[m_addr_v[1][7:0]];
    always @(posedge clk) begin
        if (m_we_v[0] === 1'b1) mem[m_addr_v[0][7:0]] <= m_out_v[0];
        if (m_we_v[1] === 1'b1) mem[m_addr_v[1][7:0]] <= m_out_v[1];
    end

    // Views of the currently selected DUT
    logic       rdy_c, done_c, we_c, jump_c;
    logic [5:0] ctrl_c;
    word_t      ax_c, ay_c, a_c, d_c, addr_c, mout_c, tgt_c;
    assign rdy_c  = sel ? if_l3.instr_ready : if_l1.instr_ready;
    assign done_c = done_v[sel];
    assign we_c   = m_we_v[sel];
    assign jump_c = jump_v[sel];
    assign ctrl_c = {zx_v[sel], nx_v[sel], zy_v[sel], ny_v[sel], f_v[sel], no_v[sel]};
    assign ax_c   = alu_x_v[sel];
    assign ay_c   = alu_y_v[sel];
    assign a_c    = a_v[sel];
    assign d_c    = d_v[sel];
    assign addr_c = m_addr_v[sel];
    assign mout_c = m_out_v[sel];
    assign tgt_c  = jt_v[sel];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: Hack computation table by mnemonic
    word_t ref_a, ref_d;
    word_t ref_mem [256];

    function automatic word_t hack_comp(logic [5:0] c, word_t dv, word_t yv);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return dv;
            6'b110000: return yv;
            6'b001101: return ~dv;
            6'b110001: return ~yv;
            6'b001111: return 16'd0 - dv;
            6'b110011: return 16'd0 - yv;
            6'b011111: return dv + 16'd1;
            6'b110111: return yv + 16'd1;
            6'b001110: return dv - 16'd1;
            6'b110010: return yv - 16'd1;
            6'b000010: return dv + yv;
            6'b010011: return dv - yv;
            6'b000111: return yv - dv;
            6'b000000: return dv & yv;
            6'b010101: return dv | yv;
            default:   return 16'hxxxx;
        endcase
    endfunction

    logic [5:0] comp_tab [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    function automatic logic [15:0] rand_instr();
        if ($urandom_range(0, 3) == 0)
            return {1'b0, 15'($urandom_range(0, 300))};
        return {3'b111, 1'($urandom_range(0, 1)), comp_tab[$urandom_range(0, 17)],
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
    endfunction

    // Issue one instruction at a negedge in IDLE; returns at the negedge after retirement
    task automatic run_instr(input logic [15:0] ins, input bit keep);
        int    lat, exp_cyc, k;
        bit    seen, is_c, exp_we, exp_jt;
        word_t yv, res, new_a, new_d;
        lat    = sel ? 3 : 1;
        is_c   = ins[15];
        yv     = ins[12] ? ref_mem[ref_a[7:0]] : ref_a;
        res    = hack_comp(ins[11:6], ref_d, yv);
        exp_we = is_c && ins[3];
        exp_jt = is_c && ((ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) ||
                          (ins[0] && $signed(res) > 0));
        new_a  = ref_a;
        new_d  = ref_d;
        if (!is_c) new_a = {1'b0, ins[14:0]};
        else begin
            if (ins[5]) new_a = res;
            if (ins[4]) new_d = res;
        end
        exp_cyc = is_c ? 1 + lat : 1;

        check("ready_idle", rdy_c, 1);
        instr_drv = ins;
        valid_drv = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) valid_drv = 1'b0;
        k    = 0;
        seen = 0;
        while (!seen && k < exp_cyc + 4) begin
            @(negedge clk);
            k++;
            if (done_c === 1'b1) seen = 1;
            else begin
                check("ready_busy", rdy_c, 0);
                if (k == 1 && is_c) begin
                    check("ctrl_bits", ctrl_c, ins[11:6]);
                    check("alu_x", ax_c, ref_d);
                    check("alu_y", ay_c, yv);
                end
            end
        end
        check("done_latency", k, exp_cyc);
        if (seen) begin
            check("ready_wb", rdy_c, 0);
            check("m_we", we_c, exp_we);
            check("jump_taken", jump_c, exp_jt);
            check("m_addr_wb", addr_c, ref_a);
            if (is_c) begin
                check("m_out", mout_c, res);
                check("jump_target", tgt_c, ref_a);
            end
            if (exp_we) ref_mem[ref_a[7:0]] = res;
        end
        @(negedge clk);
        check("done_pulse", done_c, 0);
        check("a_reg", a_c, new_a);
        check("d_reg", d_c, new_d);
        check("m_addr_follow", addr_c, new_a);
        ref_a = new_a;
        ref_d = new_d;
    endtask

    // Reset during the first EXEC cycle must abandon the instruction
    task automatic reset_mid(input logic [15:0] ins);
        instr_drv = ins;
        valid_drv = 1'b1;
        @(posedge clk);
        #1;
        valid_drv = 1'b0;
        @(negedge clk);
        check("rst_in_exec", rdy_c, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", done_c, 0);
        check("rst_no_we", we_c, 0);
        check("rst_ready", rdy_c, 1);
        check("rst_a", a_c, 0);
        check("rst_d", d_c, 0);
        ref_a = '0;
        ref_d = '0;
    endtask

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        valid_drv = 1'b0;
        instr_drv = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = word_t'($urandom);
            ref_mem[i] = mem[i];
        end
        ref_a = '0;
        ref_d = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        check("reset_ready", rdy_c, 1);
        check("reset_a", a_c, 0);
        check("reset_d", d_c, 0);
        check("reset_done", done_c, 0);
        check("reset_we", we_c, 0);
        check("reset_jump", jump_c, 0);
        check("reset_ctrl", ctrl_c, 0);
        check("reset_alu_x", ax_c, 0);
        check("reset_alu_y", ay_c, 0);

        // Directed sequence on ALU_LAT=1
        run_instr(16'h0005, 0);
        check("plan_a5", a_c, 16'd5);
        run_instr(16'hEC10, 0);
        check("plan_d5", d_c, 16'd5);
        run_instr(16'hE090, 0);
        check("plan_d10", d_c, 16'd10);
        run_instr(16'hEE90, 0);
        check("plan_dm1", d_c, 16'hFFFF);
        run_instr(16'h0064, 0);
        run_instr(16'hE308, 0);
        check("plan_mem100", mem[100], 16'hFFFF);
        run_instr(16'hEA87, 0);
        run_instr(16'hEA81, 0);

        // Back-to-back random stream with instr_valid held high
        for (int i = 0; i < 40; i++) run_instr(rand_instr(), i < 39);
        reset_mid(16'hE090);

        // Same checks on ALU_LAT=3 (held in reset state while idle)
        sel = 1'b1;
        run_instr(16'h0005, 0);
        run_instr(16'hE090, 0);
        check("l3_d5", d_c, 16'd5);
        run_instr(16'h0064, 0);
        run_instr(16'hE308, 0);
        run_instr(16'hEA87, 0);
        for (int i = 0; i < 20; i++) run_instr(rand_instr(), i < 19);
        reset_mid(16'hE090);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
